// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
// mem_dma_pkg : shared types and constants for the mem_dma copy/fill engine
// Rev 1.0 - initial release
// ============================================================================
package mem_dma_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
  localparam int MAX_LEN    = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_VR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dma_addr_gen.sv
`default_nettype none
// ============================================================================
// mem_dma_addr_gen : base registers, word index and wrapped src/dst addresses
// Rev 1.0 - initial release
// ============================================================================
module mem_dma_addr_gen
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      idx_q <= '0;
      len_q <= '0;
    end else if (load_i) begin
      src_q <= src_i;
      dst_q <= dst_i;
      len_q <= len_i;
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + ADDR_W'(1);
    end
  end

  // Sums truncate to ADDR_W bits, giving the modulo-2^ADDR_W wrap for free.
  assign src_addr_o = src_q + idx_q;
  assign dst_addr_o = dst_q + idx_q;
  assign last_o     = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == len_q);

endmodule
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// mem_dma : block copy / block fill engine for the single-port unified memory
// Optional read-back verify stage enabled by defining MEM_DMA_VERIFY_EN.
// Rev 1.0 - initial release
// ============================================================================
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              fill_q;
  logic [DATA_W-1:0] fval_q;
  logic [DATA_W-1:0] data_q;

  logic [ADDR_W:0]   w_len_sat;
  logic              w_accept;
  logic              w_inc;
  logic              w_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic [DATA_W-1:0] w_word;

  assign w_len_sat = (len > c_MAX_LEN) ? c_MAX_LEN : len;
  assign w_accept  = (state_q == ST_IDLE) && start;
  assign w_word    = fill_q ? fval_q : data_q;

`ifdef MEM_DMA_VERIFY_EN
  logic mis_q;
  assign w_inc    = (state_q == ST_VR);
  assign mismatch = mis_q;
`else
  assign w_inc    = (state_q == ST_WR);
  assign mismatch = 1'b0;
`endif

  mem_dma_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_accept),
    .inc_i     (w_inc),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (w_len_sat),
    .src_addr_o(w_src),
    .dst_addr_o(w_dst),
    .last_o    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fill_q  <= 1'b0;
      fval_q  <= '0;
      data_q  <= '0;
`ifdef MEM_DMA_VERIFY_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fill_q <= fill_mode;
            fval_q <= fill_value;
`ifdef MEM_DMA_VERIFY_EN
            mis_q  <= 1'b0;
`endif
            if (w_len_sat == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= fill_mode ? ST_WR : ST_RD;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          data_q  <= mem_rdata;
          state_q <= ST_WR;
        end
`ifdef MEM_DMA_VERIFY_EN
        ST_WR: state_q <= ST_VR;
        ST_VR: begin
          if (mem_rdata != w_word) mis_q <= 1'b1;
          if (w_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= fill_q ? ST_WR : ST_RD;
          end
        end
`else
        ST_WR: begin
          if (w_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= fill_q ? ST_WR : ST_RD;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    w_we      = 1'b0;
    case (state_q)
      ST_RD: mem_addr = w_src;
      ST_WR: begin
        mem_addr  = w_dst;
        mem_wdata = w_word;
        w_we      = 1'b1;
      end
      ST_VR:   mem_addr = w_dst;
      default: ;
    endcase
  end

  // Reset must block a write in the very cycle it is asserted, not one edge later.
  assign mem_we = w_we & rst_n;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// tb_mem_dma : scoreboard bench for mem_dma with a 4096x16 memory model
// Rev 1.0 - initial release
// ============================================================================
module tb_mem_dma;

`ifdef MEM_DMA_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    int   done_cyc;
    int   writes;
    logic mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fill_mode;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [12:0] len;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem     [4096];
  logic [15:0] ref_mem [4096];
  logic        wd_en = 1'b0;
  int          wd_addr = 0;

  int    cyc = 0;
  int    we_cnt = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  string cur_name = "reset";
  exp_t  sb[$];

  always #5 clk = ~clk;

  mem_dma #(
    .ADDR_W(12),
    .DATA_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fill_mode (fill_mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_value(fill_value),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model plus a per-transfer count of real write edges
  always @(posedge clk) begin
    if (mem_we && !(wd_en && int'(mem_addr) == wd_addr)) mem[mem_addr] = mem_wdata;
    if (!rst_n) we_cnt = 0;
    else begin
      if (done) we_cnt = 0;
      if (mem_we) we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_mem(input string nm);
    int bad = -1;
    for (int a = 0; a < 4096; a++)
      if (bad < 0 && mem[a] !== ref_mem[a]) bad = a;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: mem[%0h]=%0h expected %0h", nm, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s unexpected_done: got done=1 expected no transfer pending", cur_name);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({cur_name, " latency_cyc"}, cyc, e.done_cyc);
        chk({cur_name, " write_count"}, we_cnt, e.writes);
        chk({cur_name, " mismatch"}, {31'd0, mismatch}, {31'd0, e.mis});
        chk({cur_name, " done_bus_idle"}, {busy, mem_we, mem_addr, mem_wdata}, 32'd0);
        chk_mem({cur_name, " mem_contents"});
      end
    end
  end

  task automatic set_word(input int a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic run_xfer(input string nm, input logic fm, input int src, input int dst,
                          input int ln, input logic [15:0] fv, input bit glitch);
    int   n, lat, k;
    logic mis;
    exp_t e;
    n   = (ln > 4096) ? 4096 : ln;
    mis = 1'b0;
    // Reference: words land in ascending order, reading the current image
    for (int i = 0; i < n; i++) begin
      int a;
      logic [15:0] w;
      a = (dst + i) % 4096;
      w = fm ? fv : ref_mem[(src + i) % 4096];
      if (wd_en && a == wd_addr) mis = 1'b1;
      else ref_mem[a] = w;
    end
    if (n == 0) lat = 1;
    else if (VERIFY) lat = fm ? 2 * n + 1 : 3 * n + 1;
    else lat = fm ? n + 1 : 2 * n + 1;

    @(negedge clk);
    cur_name   = nm;
    k          = cyc;
    start      = 1'b1;
    fill_mode  = fm;
    src_addr   = src[11:0];
    dst_addr   = dst[11:0];
    len        = ln[12:0];
    fill_value = fv;
    e.done_cyc = k + lat;
    e.writes   = n;
    e.mis      = VERIFY ? mis : 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    fill_mode  = ~fm;
    src_addr   = 12'($urandom);
    dst_addr   = 12'($urandom);
    len        = 13'($urandom);
    fill_value = 16'($urandom);
    chk({nm, " busy_after_start"}, {31'd0, busy}, {31'd0, n != 0});
    if (glitch) begin
      @(negedge clk);
      start     = 1'b1;
      fill_mode = 1'b1;
      dst_addr  = dst_addr + 12'd7;
      len       = 13'd2;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 20000 && sb.size() != 0; t++) @(negedge clk);
    chk({nm, " pending_after_timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic reset_mid_copy();
    int s, d;
    s = 12'h300;
    d = 12'h500;
    cur_name = "reset_mid_copy";
    @(negedge clk);
    start     = 1'b1;
    fill_mode = 1'b0;
    src_addr  = s[11:0];
    dst_addr  = d[11:0];
    len       = 13'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (VERIFY ? 4 : 3) @(negedge clk);
    chk("rst second_wr_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst we_gated", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst idle_outputs", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
    repeat (20) @(negedge clk);
    ref_mem[d] = ref_mem[s];
    chk_mem("rst one_word_written");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    fill_mode  = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    fill_value = '0;
    for (int a = 0; a < 4096; a++) set_word(a, 16'($urandom));
    repeat (3) @(negedge clk);
    chk("reset busy",      {31'd0, busy},     32'd0);
    chk("reset done",      {31'd0, done},     32'd0);
    chk("reset mismatch",  {31'd0, mismatch}, 32'd0);
    chk("reset mem_we",    {31'd0, mem_we},   32'd0);
    chk("reset mem_addr",  {20'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_word(12'h010, 16'h1111);
    set_word(12'h011, 16'h2222);
    set_word(12'h012, 16'h3333);
    set_word(12'h013, 16'h4444);
    run_xfer("copy4", 1'b0, 12'h010, 12'h100, 4, 16'h0, 1'b0);
    run_xfer("fill_wrap", 1'b1, 0, 12'hFFE, 4, 16'hBEEF, 1'b0);
    run_xfer("len0", 1'b0, 12'h040, 12'h080, 0, 16'h0, 1'b0);
    run_xfer("ignored_start", 1'b0, 12'h600, 12'h700, 6, 16'h0, 1'b1);
    reset_mid_copy();

    set_word(12'h020, 16'hAAAA);
    set_word(12'h021, 16'hBBBB);
    set_word(12'h022, 16'hCCCC);
    run_xfer("overlap", 1'b0, 12'h020, 12'h021, 3, 16'h0, 1'b0);

    wd_en   = 1'b1;
    wd_addr = 12'h901;
    run_xfer("verify_fill", 1'b1, 0, 12'h900, 3, 16'h1234, 1'b0);
    wd_en = 1'b0;
    run_xfer("after_verify", 1'b0, 12'h900, 12'hA00, 2, 16'h0, 1'b0);

    run_xfer("sat_fill", 1'b1, 0, 12'h123, 8191, 16'h5A5A, 1'b0);
    for (int a = 0; a < 4096; a++) set_word(a, 16'($urandom));
    run_xfer("full_copy", 1'b0, 12'h800, 12'h000, 4096, 16'h0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int ln;
      ln = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 40));
      repeat ($urandom % 3) @(negedge clk);
      run_xfer($sformatf("rand%0d", r), 1'(($urandom % 2)), int'($urandom % 4096),
               int'($urandom % 4096), ln, 16'($urandom), (ln >= 4) && ($urandom % 4 == 0));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_dma.md
# mem_dma

Block-copy / block-fill engine that initiates transfers on the single-port 4096 x 16 unified memory used by the multicycle core. It sits between a control source (testbench, loader or core-side control register) and the memory port, driving write-enable, address and write-data and consuming the memory's combinational read data. The block initialises and relocates program/data regions without core involvement.

## Interface
- ADDR_W, 12: memory address width; the memory holds 2^ADDR_W words.
- DATA_W, 16: memory word width.
- clk  input  1  rising-edge clock, shared with the memory.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- fill_mode  input  1  1 = fill dst with fill_value; 0 = copy src to dst.
- src_addr  input  ADDR_W  copy source base.
- dst_addr  input  ADDR_W  destination base.
- len  input  ADDR_W+1  word count, 0..4096; values above 4096 saturate to 4096.
- fill_value  input  DATA_W  fill word.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- mismatch  output  1  sticky verify failure (see Configuration).
- mem_we  output  1  to memory MemWrite.
- mem_addr  output  ADDR_W  to memory Address.
- mem_wdata  output  DATA_W  to memory WriteData.
- mem_rdata  input  DATA_W  from memory ReadData; combinational, valid in the same cycle as mem_addr.

## Operation
- States: IDLE, RD, WR, VR (only with verify), DONE.
- IDLE: on start=1, capture src, dst, saturated len, fill_mode and fill_value; clear mismatch and the word index. If len=0, go to DONE; otherwise go to RD (copy) or WR (fill).
- RD: mem_addr = src+idx; data register <= mem_rdata at the clock edge; go to WR.
- WR: mem_addr = dst+idx; mem_we=1; mem_wdata = data register (copy) or fill_value (fill). Go to VR if verify is compiled in. Otherwise increment idx, then go to DONE if idx was the last word, else to RD (copy) or WR (fill).
- DONE: done=1 for exactly one cycle; return to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Base+idx wraps from 4095 to 0 without error.
- Copy is strictly ascending. For overlapping regions with dst > src, already-overwritten source words are re-read. This is defined behaviour, not a fault.
- start outside IDLE is ignored; no queueing.
- mem_we is 1 only in WR. mem_addr = 0 and mem_wdata = 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, busy 0, done 0, mismatch 0, mem_we 0, mem_addr 0, mem_wdata 0, idx 0.
- rst_n low mid-transfer: the state returns to IDLE at the next edge. mem_we is also gated combinationally by rst_n, so no write occurs in any cycle where rst_n=0. No done pulse is produced.
- busy = 1 in RD, WR and VR; otherwise 0.
- Copy latency: 2N cycles in RD/WR after the start edge, then 1 DONE cycle. done asserts 2N+1 cycles after the start edge.
- Fill latency: N WR cycles, done at N+1.
- len=0: done asserts in the first cycle after the start edge; no memory access.
- A new start is accepted in the cycle after DONE at the earliest.

## Configuration
- MEM_DMA_VERIFY_EN defined:
  - VR state follows every WR. It re-reads dst+idx and compares mem_rdata with the written word.
  - On inequality, mismatch is set and stays set until the next accepted start. The transfer continues.
  - Costs one extra cycle per word: copy 3N+1, fill 2N+1.
- Not defined: no VR state; mismatch is tied to 0.

## Structure
- Package mem_dma_pkg: state enum type, default ADDR_W/DATA_W localparams, and the MAX_LEN = 2^ADDR_W constant.
- One sub-module, mem_dma_addr_gen: holds the base registers and idx, and produces the wrapped src/dst addresses plus a last-word flag. The FSM stays in mem_dma.

## Test plan
- Copy: mem[0x010..0x013] = 1111,2222,3333,4444; start copy src=0x010, dst=0x100, len=4 -> mem[0x100..0x103] equal source; done exactly 9 cycles after the start edge; exactly 4 write cycles.
- Fill with wrap: dst=0xFFE, len=4, fill_value=0xBEEF -> mem[0xFFE], mem[0xFFF], mem[0x000], mem[0x001] = BEEF; done at cycle 5.
- len=0 and ignored start: start len=0 -> done at cycle 1, mem_we never high. Start pulsed while busy -> no effect on the running transfer.
- Reset mid-copy: assert rst_n=0 during the second WR of a len=8 copy -> no write in the reset cycle, IDLE next, no done, only 1 destination word modified.
- Overlap: mem[0x20..0x22] = A,B,C; copy src=0x20, dst=0x21, len=3 -> mem[0x21..0x23] = A,A,A.
- Verify (MEM_DMA_VERIFY_EN): force memory model write-disable at dst+1 during a fill of len=3 -> mismatch=1 after the VR cycle of word 1; done at cycle 7; mismatch cleared by the next start.
